// File: rtl/CPU_Types.sv
// Shared CPU constants for the inter-stage pipeline buffers.
package CPU_Types;

    localparam int unsigned BUF_DEPTH_FETCH  = 2;
    localparam int unsigned BUF_DEPTH_DECODE = 2;

    // Bits needed to hold an occupancy value in the range 0..depth inclusive.
    function automatic int unsigned clog2p1(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cpu_buffer_ptr.sv
// Modulo-DEPTH pointer with synchronous clear; wraps explicitly at DEPTH-1.
module cpu_buffer_ptr #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_inc,
    input  logic          i_clear,
    output logic [PW-1:0] o_ptr
);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            o_ptr <= '0;
        end else if (i_clear) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            if (o_ptr == PW'(DEPTH - 1)) begin
                o_ptr <= '0;
            end else begin
                o_ptr <= o_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_pipeline_buffer.sv
// Elastic valid/ready buffer between CPU pipeline stages with flush,
// occupancy count, almost-full flag and optional fall-through when empty.
module cpu_pipeline_buffer
    import CPU_Types::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned FALLTHROUGH = 0,
    parameter int unsigned AF_MARGIN   = 1
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_flush,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [DW-1:0]               i_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [DW-1:0]               o_data,
    output logic [clog2p1(DEPTH)-1:0]   o_count,
    output logic                        o_almost_full
);

    localparam int unsigned CW    = clog2p1(DEPTH);
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AF_TH = DEPTH - AF_MARGIN;

    if (DW < 1) begin : g_bad_dw
        $error("cpu_pipeline_buffer: DW must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("cpu_pipeline_buffer: DEPTH must be at least 1");
    end
    if (AF_MARGIN >= DEPTH) begin : g_bad_margin
        $error("cpu_pipeline_buffer: AF_MARGIN must be below DEPTH");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          store;
    logic          drain;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    // Bypass is gated by reset so outputs hold their reset values while in reset.
    assign bypass = (FALLTHROUGH != 0) && empty && i_reset;

    // o_ready depends only on registered count, never on i_ready.
    assign o_ready = ~full & ~i_flush;
    assign o_valid = (bypass ? i_valid : ~empty) & ~i_flush;
    assign o_data  = bypass ? i_data : mem[rd_ptr];

    assign push  = i_valid & o_ready;
    assign pop   = o_valid & i_ready;
    // A bypassed word consumed in the same cycle never touches storage.
    assign store = push & ~(bypass & pop);
    assign drain = pop & ~bypass;

    assign o_count = count;

    if (AF_TH == 0) begin : g_af_always
        assign o_almost_full = 1'b1;
    end else begin : g_af_cmp
        assign o_almost_full = (count >= CW'(AF_TH));
    end

    cpu_buffer_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (store),
        .i_clear (i_flush),
        .o_ptr   (wr_ptr)
    );

    cpu_buffer_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (drain),
        .i_clear (i_flush),
        .o_ptr   (rd_ptr)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_flush) begin
            count <= '0;
        end else if (store && !drain) begin
            count <= count + CW'(1);
        end else if (drain && !store) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (store) begin
            mem[wr_ptr] <= i_data;
        end
    end

endmodule

// File: doc/cpu_pipeline_buffer.md
Name: cpu_pipeline_buffer

Overview:
- Parametrised elastic buffer between CPU pipeline stages.
- Successor to the single-entry stall-hold skid buffer; replaces the global busy stall with a per-stage valid/ready handshake.
- Adds configurable depth, an optional fall-through mode, flush on jump/IRQ, occupancy count and an almost-full flag.
- Placement: fetch→decode and decode→execute, carrying fetch_data_t / decode_data_t as flat DW-bit vectors.

Parameters:
- DW, 32: payload width in bits (≥1).
- DEPTH, 2: number of storage entries (≥1; need not be a power of two).
- FALLTHROUGH, 0: 0 = registered, 1-cycle latency; 1 = combinational bypass when empty.
- AF_MARGIN, 1: o_almost_full asserts when count ≥ DEPTH−AF_MARGIN (0 ≤ AF_MARGIN < DEPTH).

Ports:
- i_clock  in  1  CPU clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_flush  in  1  discard all contents (driven by jump/IRQ dispatch).
- i_valid  in  1  upstream data valid.
- o_ready  out  1  buffer can accept.
- i_data  in  DW  upstream payload.
- o_valid  out  1  downstream data valid.
- i_ready  in  1  downstream accepts.
- o_data  out  DW  head payload.
- o_count  out  CW  occupancy, CW = $clog2(DEPTH+1).
- o_almost_full  out  1  occupancy ≥ DEPTH−AF_MARGIN.

Behaviour:
- Reset (i_reset low, asynchronous): write/read pointers 0, count 0, all entries 0.
  - Outputs during reset: o_valid 0, o_data 0, o_count 0, o_ready 1, o_almost_full 0 unless DEPTH−AF_MARGIN = 0.
  - Reset takes effect mid-transfer with no partial writes; the first accept is on the first rising edge after release.
- push = i_valid & o_ready; pop = o_valid & i_ready.
- o_ready = (count != DEPTH) & ~i_flush.
  - No combinational path from i_ready to o_ready: a full buffer does not accept in the cycle it pops.
- FALLTHROUGH=0:
  - o_valid = (count != 0) & ~i_flush; o_data = mem[rd_ptr].
  - Push-to-o_valid latency is 1 cycle.
- FALLTHROUGH=1:
  - When count=0: o_valid = i_valid & ~i_flush and o_data = i_data combinationally.
  - push & pop in the same empty cycle does not write storage; count stays 0.
  - When count>0: behaves as FALLTHROUGH=0.
- Storage: push writes mem[wr_ptr]; pointers advance by 1 and wrap explicitly from DEPTH−1 to 0 (modulo compare, not bit truncation).
- Count:
  - +1 on push only, −1 on pop only, unchanged on push&pop (including the full-with-pop case, where push is impossible by rule).
  - Never exceeds DEPTH, never underflows.
- Flush (highest priority):
  - In the flush cycle, o_valid=0 and o_ready=0, so no transfer occurs.
  - Next edge: pointers 0, count 0.
  - Stored data is left stale, unobservable because o_valid=0.
  - Flush while empty is a no-op; consecutive flush cycles are allowed.
- o_data when o_valid=0: undefined; the bench must not check it (except 0 after reset).
- o_almost_full: combinational from the registered count.
- Elaboration assertions: DEPTH ≥ 1; AF_MARGIN < DEPTH; DW ≥ 1.

Decomposition:
- No new typedefs.
- Package constants in CPU_Types: BUF_DEPTH_FETCH=2, BUF_DEPTH_DECODE=2, and the buffer-count-width helper function clog2p1.
- One sub-module, cpu_buffer_ptr: modulo-DEPTH pointer with i_inc and i_clear, instantiated for the read and write pointers.
- Storage array, count and handshake logic stay inline.

Test Plan:
1. Reset, DEPTH=4, FALLTHROUGH=0, AF_MARGIN=1 → o_valid=0, o_ready=1, o_count=0, o_data=0. Push 0xA1,0xA2,0xA3 back-to-back with i_ready=0 → o_count=3, o_almost_full=1, o_ready=1. Push 0xA4 → o_count=4, o_ready=0.
2. Full DEPTH=4 with i_ready=1 for 4 cycles → pops 0xA1..0xA4 in order; o_ready rises the cycle after the first pop; o_count goes 4,3,2,1,0.
3. Wrap, DEPTH=3: push/pop 10 items 0x00..0x09 with random i_valid/i_ready (seeded) → output order identical and count never exceeds 3; pointers wrap at 2→0.
4. FALLTHROUGH=1, empty, i_valid=1, i_data=0x55, i_ready=1 → o_valid=1 and o_data=0x55 in the same cycle; o_count stays 0. Repeat with i_ready=0 → stored, o_count=1 next cycle.
5. Flush at count=3, with i_valid=1 in the same cycle → o_ready=0 and o_valid=0 that cycle; next cycle o_count=0 and o_valid=0; the input is not stored.
6. Assert i_reset low asynchronously mid-stream at count=2 (between edges) → outputs return to reset values immediately. Release, push 0x77 → it emerges first after 1 cycle.
